// File: rtl/md_unit_pkg.sv
// Shared types for the multiply/divide unit.
// Holds the MD_OP_* operation encodings, the FSM state encoding and the
// packed {hi,lo} result payload produced by md_arith.
package md_unit_pkg;

    localparam int unsigned MD_OP_LEN = 4;
    localparam int unsigned XLEN      = 32;

    typedef enum logic [MD_OP_LEN-1:0] {
        MD_OP_NONE  = 4'd0,
        MD_OP_MULT  = 4'd1,
        MD_OP_MULTU = 4'd2,
        MD_OP_DIV   = 4'd3,
        MD_OP_DIVU  = 4'd4,
        MD_OP_MFHI  = 4'd5,
        MD_OP_MFLO  = 4'd6,
        MD_OP_MTHI  = 4'd7,
        MD_OP_MTLO  = 4'd8
    } md_op_t;

    typedef enum logic [0:0] {
        MD_STATE_IDLE = 1'b0,
        MD_STATE_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_res_t;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic md_is_arith(input md_op_t op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op_i          - MD_OP_* operation; only MULT/MULTU/DIV/DIVU produce a result
//   a_i, b_i      - operands (rs, rt)
//   res_o         - {hi,lo}: product halves, or remainder/quotient
//   div_by_zero_o - divide op with b_i == 0; result must not be committed
module md_arith
    import md_unit_pkg::*;
(
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output md_res_t         res_o,
    output logic            div_by_zero_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] NEG_ONE = {XLEN{1'b1}};

    logic signed [2*XLEN-1:0] prod_s;
    logic        [2*XLEN-1:0] prod_u;

    // Sign-extend before multiplying so the low 64 bits are the exact signed product.
    assign prod_s = (2*XLEN)'($signed(a_i)) * (2*XLEN)'($signed(b_i));
    assign prod_u = (2*XLEN)'(a_i) * (2*XLEN)'(b_i);

    always_comb begin
        res_o         = '0;
        div_by_zero_o = 1'b0;
        unique case (op_i)
            MD_OP_MULT: begin
                res_o = md_res_t'(prod_s);
            end
            MD_OP_MULTU: begin
                res_o = md_res_t'(prod_u);
            end
            MD_OP_DIV: begin
                if (b_i == '0) begin
                    div_by_zero_o = 1'b1;
                end else if ((a_i == INT_MIN) && (b_i == NEG_ONE)) begin
                    // Overflowing quotient wraps to INT_MIN with zero remainder.
                    res_o.lo = INT_MIN;
                    res_o.hi = '0;
                end else begin
                    // Verilog signed / and % truncate toward zero; remainder follows the dividend.
                    res_o.lo = XLEN'($signed(a_i) / $signed(b_i));
                    res_o.hi = XLEN'($signed(a_i) % $signed(b_i));
                end
            end
            MD_OP_DIVU: begin
                if (b_i == '0) begin
                    div_by_zero_o = 1'b1;
                end else begin
                    res_o.lo = a_i / b_i;
                    res_o.hi = a_i % b_i;
                end
            end
            default: begin
                res_o         = '0;
                div_by_zero_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   md_op_e     - MD_OP_* of the instruction in execute
//   rs_e, rt_e  - forwarded operands in execute
//   md_use_d    - instruction in decode touches the unit
//   md_result   - HI for MFHI, LO for MFLO, else 0 (combinational)
//   busy        - multi-cycle op in flight
//   stall       - decode hold request (combinational)
//   hi, lo      - committed HI/LO registers
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  md_op_t          md_op_e,
    input  logic [XLEN-1:0] rs_e,
    input  logic [XLEN-1:0] rt_e,
    input  logic            md_use_d,
    output logic [XLEN-1:0] md_result,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    md_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_res_t         pend_q, pend_d;
    logic            pend_wr_q, pend_wr_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    md_res_t         arith_res;
    logic            arith_dbz;
    logic            start_e;

    md_arith u_arith (
        .op_i          (md_op_e),
        .a_i           (rs_e),
        .b_i           (rt_e),
        .res_o         (arith_res),
        .div_by_zero_o (arith_dbz)
    );

    assign start_e = md_is_arith(md_op_e) && (state_q == MD_STATE_IDLE);

    // Next-state: latch operands' result on start, count down, commit on the last busy cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            MD_STATE_IDLE: begin
                if (start_e) begin
                    pend_d    = arith_res;
                    pend_wr_d = ~arith_dbz;
                    cnt_d     = md_is_div(md_op_e) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d   = MD_STATE_BUSY;
                end else if (md_op_e == MD_OP_MTHI) begin
                    hi_d = rs_e;
                end else if (md_op_e == MD_OP_MTLO) begin
                    lo_d = rs_e;
                end
            end
            MD_STATE_BUSY: begin
                // Ops arriving while busy are ignored; decode stall prevents them.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_STATE_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
            default: begin
                state_d = MD_STATE_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight op without commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_STATE_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = (state_q == MD_STATE_BUSY);
    assign stall = md_use_d && (busy || start_e);
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Moves-from read committed registers; an MT* one cycle earlier has already landed.
    always_comb begin
        md_result = '0;
        if (md_op_e == MD_OP_MFHI) begin
            md_result = hi_q;
        end else if (md_op_e == MD_OP_MFLO) begin
            md_result = lo_q;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with an expected-result queue for HI/LO commits.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    md_op_t      md_op_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic [31:0] md_result;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp  = 0;
    int          n_fail = 0;
    md_res_t     sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_op_e   (md_op_e),
        .rs_e      (rs_e),
        .rt_e      (rt_e),
        .md_use_d  (md_use_d),
        .md_result (md_result),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Any op presented while the unit is busy is a protocol error of the stimulus.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && busy === 1'b1 && md_op_e !== MD_OP_NONE) begin
            n_cmp++;
            n_fail++;
            $error("FAIL protocol: op 0x%0h observed while busy, expected MD_OP_NONE", md_op_e);
        end
    end

    // Called at a negedge with the unit idle; returns at the negedge where busy has fallen.
    task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int unsigned n_exp);
        md_res_t e;
        int      n;
        int      n_stall;
        e.hi = eh;
        e.lo = el;
        md_op_e = op;
        rs_e    = a;
        rt_e    = b;
        sb.push_back(e);
        #1;
        check({tag, "_busy_at_start"}, 32'(busy), 32'd0);
        check({tag, "_stall_at_start"}, 32'(stall), 32'(md_use_d));
        n_stall = (stall === 1'b1) ? 1 : 0;
        @(negedge clk);
        md_op_e = MD_OP_NONE;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall === 1'b1) n_stall++;
            check({tag, "_hold_hi"}, hi, m_hi);
            check({tag, "_hold_lo"}, lo, m_lo);
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(n_exp));
        check({tag, "_stall_cycles"}, 32'(n_stall), md_use_d ? 32'(n_exp + 1) : 32'd0);
        check({tag, "_stall_after"}, 32'(stall), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        md_op_e  = MD_OP_NONE;
        rs_e     = '0;
        rt_e     = '0;
        md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("nonmd_no_stall", 32'(stall), 32'd0);
        md_use_d = 1'b0;
        rst_n    = 1'b1;
        m_hi     = '0;
        m_lo     = '0;
        @(negedge clk);

        run_op("mult", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        md_op_e = MD_OP_MFLO;
        #1 check("mflo", md_result, 32'hFFFF_FFFA);
        md_op_e = MD_OP_MFHI;
        #1 check("mfhi", md_result, 32'hFFFF_FFFF);
        md_op_e = MD_OP_NONE;
        #1 check("result_none", md_result, 32'h0);
        @(negedge clk);

        run_op("multu", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);

        md_use_d = 1'b1;
        run_op("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        md_use_d = 1'b0;

        run_op("divu_by0", MD_OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        run_op("div_negdivisor", MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 10);

        md_op_e = MD_OP_MTHI;
        rs_e    = 32'h1234_5678;
        @(negedge clk);
        md_op_e = MD_OP_MFHI;
        #1 check("mthi_mfhi", md_result, 32'h1234_5678);
        check("mthi_lo_kept", lo, 32'hFFFF_FFFD);
        @(negedge clk);
        md_op_e = MD_OP_MTLO;
        rs_e    = 32'hCAFE_F00D;
        @(negedge clk);
        md_op_e = MD_OP_MFLO;
        #1 check("mtlo_mflo", md_result, 32'hCAFE_F00D);
        check("mtlo_hi_kept", hi, 32'h1234_5678);
        md_op_e = MD_OP_NONE;
        m_hi    = 32'h1234_5678;
        m_lo    = 32'hCAFE_F00D;
        @(negedge clk);

        // Second op issued in the same cycle busy falls.
        run_op("mult_neg", MD_OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        run_op("divu_b2b", MD_OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, 10);

        // Abort a MULT with reset during its third busy cycle.
        md_op_e = MD_OP_MULT;
        rs_e    = 32'd3;
        rt_e    = 32'd3;
        @(negedge clk);
        md_op_e = MD_OP_NONE;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_commit_hi", hi, 32'h0);
        check("no_commit_lo", lo, 32'h0);
        check("no_commit_busy", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
